// File: rtl/tl45_pkg.sv
// Shared tl45 types: opcodes, instruction field positions, decode->ALU buffer.
// Also holds the operand-select helper used by the decode stage.
package tl45_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int NREGS  = 1 << REG_W;

  typedef enum logic [4:0] {
    OP_NOP = 5'h00
  } opcode_e;

  localparam opcode_e NOP_OPCODE = OP_NOP;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int MODE_BIT = 26;
  localparam int DR_LSB   = 22;
  localparam int SR1_LSB  = 18;
  localparam int SR2_LSB  = 14;
  localparam int IMM_MSB  = 15;

  typedef struct packed {
    opcode_e             opcode;
    logic [REG_W-1:0]    dr;
    logic [REG_W-1:0]    sr1;
    logic [REG_W-1:0]    sr2;
    logic [DATA_W-1:0]   sr1_val;
    logic [DATA_W-1:0]   sr2_val;
    logic [31:0]         pc;
  } alu_buf_t;

  // r0 reads as zero; the ALU result outranks the (already bypassed) regfile value.
  function automatic logic [DATA_W-1:0] operand(
    input logic [REG_W-1:0]  sr,
    input logic [REG_W-1:0]  fwd_dr,
    input logic [DATA_W-1:0] fwd_val,
    input logic [DATA_W-1:0] rf_val
  );
    if (sr == '0) return '0;
    if (sr == fwd_dr) return fwd_val;
    return rf_val;
  endfunction

endpackage

// File: rtl/tl45_regfile.sv
// 16 x DATA_W register file: two async reads, one sync write, r0 fixed at zero.
// Reads of the register being written this cycle return the write data.
module tl45_regfile
  import tl45_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_W-1:0]  i_ra1,
  input  logic [REG_W-1:0]  i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic              wr_en;

  assign wr_en = i_we && (i_wa != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : (wr_en && i_wa == i_ra1) ? i_wd : mem_q[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : (wr_en && i_wa == i_ra2) ? i_wd : mem_q[i_ra2];

endmodule

// File: rtl/tl45_decode.sv
// Decode/register-read stage feeding tl45_alu; one cycle inst -> ALU buffer.
// Holds on downstream stall, bubbles one cycle on a RAW hit against the buffered op.
module tl45_decode
  import tl45_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pipe_stall,
  input  logic              i_pipe_flush,
  output logic              o_pipe_stall,
  output logic              o_pipe_flush,
  input  logic [31:0]       i_buf_inst,
  input  logic [31:0]       i_buf_pc,
  input  logic [REG_W-1:0]  i_fwd_dr,
  input  logic [DATA_W-1:0] i_fwd_val,
  input  logic              i_wb_we,
  input  logic [REG_W-1:0]  i_wb_dr,
  input  logic [DATA_W-1:0] i_wb_val,
  output logic [4:0]        o_opcode,
  output logic [REG_W-1:0]  o_dr,
  output logic [REG_W-1:0]  o_sr1,
  output logic [REG_W-1:0]  o_sr2,
  output logic [DATA_W-1:0] o_sr1_val,
  output logic [DATA_W-1:0] o_sr2_val,
  output logic [31:0]       o_pc
);

  alu_buf_t          buf_q, buf_d;
  logic              mode;
  logic [REG_W-1:0]  dr, sr1, sr2_raw, sr2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, imm_sext;
  logic              hazard;

  assign mode     = i_buf_inst[MODE_BIT];
  assign dr       = i_buf_inst[DR_LSB +: REG_W];
  assign sr1      = i_buf_inst[SR1_LSB +: REG_W];
  assign sr2_raw  = i_buf_inst[SR2_LSB +: REG_W];
  assign sr2      = mode ? '0 : sr2_raw;
  assign imm_sext = {{(DATA_W-16){i_buf_inst[IMM_MSB]}}, i_buf_inst[IMM_MSB:0]};

  tl45_regfile u_regfile (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ra1   (sr1),
    .i_ra2   (sr2),
    .o_rd1   (rf_rd1),
    .o_rd2   (rf_rd2),
    .i_we    (i_wb_we),
    .i_wa    (i_wb_dr),
    .i_wd    (i_wb_val)
  );

  // The buffered op's result is not on i_fwd_* yet, so a reader of its dr must wait a cycle.
  assign hazard = (buf_q.opcode != NOP_OPCODE) && (buf_q.dr != '0) &&
                  ((sr1 == buf_q.dr) || (!mode && sr2_raw == buf_q.dr));

  always_comb begin
    buf_d         = '0;
    buf_d.opcode  = opcode_e'(i_buf_inst[OPC_MSB:OPC_LSB]);
    buf_d.dr      = dr;
    buf_d.sr1     = sr1;
    buf_d.sr2     = sr2;
    buf_d.sr1_val = operand(sr1, i_fwd_dr, i_fwd_val, rf_rd1);
    buf_d.sr2_val = mode ? imm_sext : operand(sr2, i_fwd_dr, i_fwd_val, rf_rd2);
    buf_d.pc      = i_buf_pc;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      buf_q <= '0;
    end else if (i_pipe_flush) begin
      buf_q <= '0;
    end else if (!i_pipe_stall) begin
      buf_q <= hazard ? '0 : buf_d;
    end
  end

  assign o_pipe_stall = i_pipe_stall || (hazard && !i_pipe_flush);
  assign o_pipe_flush = i_pipe_flush;

  assign o_opcode  = buf_q.opcode;
  assign o_dr      = buf_q.dr;
  assign o_sr1     = buf_q.sr1;
  assign o_sr2     = buf_q.sr2;
  assign o_sr1_val = buf_q.sr1_val;
  assign o_sr2_val = buf_q.sr2_val;
  assign o_pc      = buf_q.pc;

endmodule

// File: doc/tl45_decode.md
Name: tl45_decode

Overview:
- Decode/register-read stage directly upstream of tl45_alu.
- Latches the fetched instruction word and splits it into fields.
- Reads the 16x32 register file, with forwarding from the ALU result and writeback.
- Drives the ALU input buffer (opcode, dr, sr1, sr2, operand values, pc).
- Passes stall/flush upstream, adding its own stall on back-to-back RAW hazards.

Parameters:
- DATA_W, 32, register/operand width.
- REG_W, 4, register index width (16 regs, r0 hardwired zero).
- NOP_OPCODE, 5'h00, opcode used for bubbles; treated as non-writing.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_pipe_stall  in  1  stall from ALU stage.
- i_pipe_flush  in  1  flush from ALU stage.
- o_pipe_stall  out  1  stall to fetch.
- o_pipe_flush  out  1  flush to fetch.
- i_buf_inst  in  32  instruction from fetch buffer.
- i_buf_pc  in  32  pc of i_buf_inst.
- i_fwd_dr  in  REG_W  ALU output dr (tl45_alu o_dr).
- i_fwd_val  in  DATA_W  ALU output value (tl45_alu o_val).
- i_wb_we  in  1  writeback enable.
- i_wb_dr  in  REG_W  writeback register.
- i_wb_val  in  DATA_W  writeback value.
- o_opcode  out  5  to ALU.
- o_dr, o_sr1, o_sr2  out  REG_W  to ALU.
- o_sr1_val, o_sr2_val  out  DATA_W  to ALU.
- o_pc  out  32  to ALU.

Behaviour:
- Reset value of every output is 0.
- Reset (i_reset==0 at a clock edge): output buffer = NOP (all zero), register file cleared, hazard stall cleared.
- Instruction fields:
  - opcode = [31:27]; imm mode bit = [26]; dr = [25:22]; sr1 = [21:18]; sr2 = [17:14]; imm16 = [15:0].
  - When mode=1, sr2 is forced to 0 and o_sr2_val = sign-extended imm16.
- Latency: one cycle from i_buf_inst to the output buffer.
- Operand value priority (per source, computed combinationally, then registered):
  1. sr==0 -> 0.
  2. sr==i_fwd_dr and i_fwd_dr!=0 -> i_fwd_val.
  3. i_wb_we and sr==i_wb_dr and i_wb_dr!=0 -> i_wb_val.
  4. Otherwise register file.
- Register file:
  - Write on the clock edge when i_wb_we and i_wb_dr!=0.
  - Writes to r0 are ignored.
- Hazard:
  - hazard = (buffered o_opcode != NOP_OPCODE) and (o_dr!=0) and (sr1==o_dr or (mode==0 and sr2==o_dr)).
  - The ALU result for the buffered instruction is not yet visible on i_fwd_*.
- Buffer update each edge, in priority order:
  1. Reset.
  2. i_pipe_flush: buffer <= NOP.
  3. i_pipe_stall: hold.
  4. hazard: buffer <= NOP bubble; fetch held via o_pipe_stall.
  5. Otherwise: latch the decoded instruction.
- o_pipe_stall = i_pipe_stall || (hazard && !i_pipe_flush). Combinational.
- o_pipe_flush = i_pipe_flush. Combinational, same cycle.
- Hazard self-clears:
  - After the bubble, the dependent producer appears on i_fwd_*, so at most one bubble is inserted per dependency.
- Simultaneous events:
  - Flush beats stall and hazard.
  - Stall beats hazard: hold the buffer, no bubble inserted.
  - A writeback in the same cycle as a read of the same register returns i_wb_val (write-through).

Decomposition:
- Package tl45_pkg holds:
  - opcode typedef (5-bit enum, NOP=0);
  - instruction field bit positions;
  - DATA_W/REG_W constants;
  - a packed struct for the decode->ALU buffer, shared with tl45_alu.
- Sub-module tl45_regfile: 16xDATA_W, 2 async read ports, 1 sync write port, r0=0, reset clears, write-through bypass.

Test Plan:
- Reset:
  - Hold i_reset=0 for 2 cycles with inst=32'hFFFF_FFFF -> all outputs 0, o_pipe_stall=0.
  - Release reset -> first decode appears 1 cycle later.
- Immediate decode:
  - inst with opcode=3, mode=1, dr=2, sr1=1, imm=16'hFFFE; r1=5 -> next cycle o_opcode=3, o_dr=2, o_sr1_val=5, o_sr2=0, o_sr2_val=32'hFFFF_FFFE.
- RAW hazard:
  - Instr A writes r3; next instr B reads sr1=3.
  - o_pipe_stall=1 for exactly one cycle; one NOP bubble is issued.
  - Then B issues with o_sr1_val = i_fwd_val (e.g. 32'h1234) on a cycle where i_fwd_dr=3.
- Writeback bypass:
  - i_wb_we=1, i_wb_dr=7, i_wb_val=32'hDEAD_BEEF while decoding sr2=7 -> o_sr2_val=32'hDEAD_BEEF.
  - Subsequent read of r7 still returns DEADBEEF.
  - Write to r0 (i_wb_dr=0, val 9) -> reads of r0 return 0.
- Stall/flush priority:
  - i_pipe_stall=1 for 3 cycles -> outputs held constant, o_pipe_stall=1.
  - Assert i_pipe_flush together with i_pipe_stall and a hazard -> o_pipe_flush=1 same cycle; next cycle buffer is NOP; o_pipe_stall equals i_pipe_stall only.
- Mid-operation reset:
  - Assert i_reset=0 during a hazard stall -> next edge buffer NOP, register file zero, stall cleared.
